// File: rtl/lfsr_pkg.sv
// Shared opcodes, FSM state encoding and LFSR next-state function for lfsr_ctrl.
`default_nettype none

package lfsr_pkg;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_STEP = 2'b01;
  localparam logic [1:0] OP_RUN  = 2'b10;
  localparam logic [1:0] OP_STOP = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Right-shifting Fibonacci step: feedback parity enters at bit 7.
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur, input logic [7:0] taps);
    return {^(cur & taps), cur[7:1]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr8_core.sv
// 8-bit LFSR register with synchronous load (priority over shift).
`default_nettype none

module lfsr8_core
  import lfsr_pkg::*;
#(
  parameter logic [7:0] RST_SEED = 8'h01,
  parameter logic [7:0] TAPS     = 8'b0001_1101
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       shift_en,
  output logic [7:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_SEED;
    end else if (load) begin
      q <= load_val;
    end else if (shift_en) begin
      q <= lfsr_next(q, TAPS);
    end
  end

endmodule

`default_nettype wire

// File: rtl/lfsr_ctrl.sv
// LFSR command controller: LOAD/STEP/RUN/STOP sequencing, shift counter and seed-return detect.
`default_nettype none

module lfsr_ctrl
  import lfsr_pkg::*;
#(
  parameter logic [7:0] RST_SEED = 8'h01,
  parameter logic [7:0] TAPS     = 8'b0001_1101
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_arg,
  output logic [7:0] lfsr_q,
  output logic       busy,
  output logic       done,
  output logic       lockup,
  output logic [7:0] shift_cnt,
  output logic       seed_hit
);

  state_t     state, state_nxt;
  logic [7:0] step_cnt, step_nxt;
  logic [7:0] seed;
  logic       accept;
  logic       load;
  logic       shift_en;
  logic       done_nxt;

  assign cmd_ready = (state != ST_STEP);
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != ST_IDLE);
  assign lockup    = (lfsr_q == 8'h00);

  lfsr8_core #(
    .RST_SEED(RST_SEED),
    .TAPS    (TAPS)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .load_val(cmd_arg),
    .shift_en(shift_en),
    .q       (lfsr_q)
  );

  always_comb begin
    state_nxt = state;
    step_nxt  = step_cnt;
    load      = 1'b0;
    shift_en  = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_LOAD: begin
              load     = 1'b1;
              done_nxt = 1'b1;
            end
            OP_STEP: begin
              // A zero count or a locked-up register completes immediately.
              if (cmd_arg == 8'd0 || lockup) begin
                done_nxt = 1'b1;
              end else begin
                state_nxt = ST_STEP;
                step_nxt  = cmd_arg;
              end
            end
            OP_RUN:  state_nxt = ST_RUN;
            default: ;
          endcase
        end
      end
      ST_STEP: begin
        if (lockup) begin
          state_nxt = ST_IDLE;
          step_nxt  = 8'd0;
          done_nxt  = 1'b1;
        end else begin
          shift_en = 1'b1;
          step_nxt = step_cnt - 8'd1;
          if (step_cnt == 8'd1) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // STOP still shifts on its accepting edge; other opcodes are dropped.
        if (lockup) begin
          state_nxt = ST_IDLE;
        end else begin
          shift_en = 1'b1;
          if (accept && cmd_op == OP_STOP) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      step_cnt  <= 8'd0;
      seed      <= RST_SEED;
      shift_cnt <= 8'd0;
      done      <= 1'b0;
      seed_hit  <= 1'b0;
    end else begin
      state    <= state_nxt;
      step_cnt <= step_nxt;
      done     <= done_nxt;
      seed_hit <= shift_en && (lfsr_next(lfsr_q, TAPS) == seed);
      if (load) begin
        seed      <= cmd_arg;
        shift_cnt <= 8'd0;
      end else if (shift_en) begin
        shift_cnt <= shift_cnt + 8'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lfsr_ctrl.sv
// Directed self-checking bench for lfsr_ctrl with hand-computed expected values.
`default_nettype none

module tb_lfsr_ctrl;
  import lfsr_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_arg;
  logic [7:0] lfsr_q;
  logic       busy;
  logic       done;
  logic       lockup;
  logic [7:0] shift_cnt;
  logic       seed_hit;

  int checks = 0;
  int errors = 0;

  lfsr_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_arg  (cmd_arg),
    .lfsr_q   (lfsr_q),
    .busy     (busy),
    .done     (done),
    .lockup   (lockup),
    .shift_cnt(shift_cnt),
    .seed_hit (seed_hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin : stim
    logic [7:0] step_exp [5];
    int hits;
    step_exp[0] = 8'h80; step_exp[1] = 8'h40; step_exp[2] = 8'h20;
    step_exp[3] = 8'h10; step_exp[4] = 8'h88;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = OP_LOAD; cmd_arg = 8'h00;
    tick(); tick();
    chk("rst_lfsr", lfsr_q, 8'h01);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_done", {7'd0, done}, 8'd0);
    chk("rst_cnt", shift_cnt, 8'd0);
    chk("rst_hit", {7'd0, seed_hit}, 8'd0);
    rst_n = 1'b1;
    tick();
    chk("rel_ready", {7'd0, cmd_ready}, 8'd1);
    chk("rel_lockup", {7'd0, lockup}, 8'd0);

    // LOAD 0x01
    issue(OP_LOAD, 8'h01);
    chk("load_q", lfsr_q, 8'h01);
    chk("load_done", {7'd0, done}, 8'd1);
    chk("load_cnt", shift_cnt, 8'd0);
    tick();
    chk("load_done_clr", {7'd0, done}, 8'd0);

    // STEP 5
    issue(OP_STEP, 8'd5);
    chk("step_busy0", {7'd0, busy}, 8'd1);
    chk("step_q0", lfsr_q, 8'h01);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("step_q%0d", i + 1), lfsr_q, step_exp[i]);
      chk($sformatf("step_busy%0d", i + 1), {7'd0, busy}, (i < 4) ? 8'd1 : 8'd0);
      chk($sformatf("step_done%0d", i + 1), {7'd0, done}, (i < 4) ? 8'd0 : 8'd1);
    end
    chk("step_cnt", shift_cnt, 8'd5);
    tick();
    chk("step_done_clr", {7'd0, done}, 8'd0);
    chk("step_frozen", lfsr_q, 8'h88);

    // Command held during STEP 3 is only accepted once IDLE
    issue(OP_LOAD, 8'h01);
    issue(OP_STEP, 8'd3);
    cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_arg = 8'h5A;
    tick();
    chk("hold_ready1", {7'd0, cmd_ready}, 8'd0);
    tick();
    chk("hold_ready2", {7'd0, cmd_ready}, 8'd0);
    chk("hold_q2", lfsr_q, 8'h40);
    tick();
    chk("hold_q3", lfsr_q, 8'h20);
    chk("hold_done3", {7'd0, done}, 8'd1);
    chk("hold_ready3", {7'd0, cmd_ready}, 8'd1);
    tick();
    cmd_valid = 1'b0;
    chk("hold_load_q", lfsr_q, 8'h5A);
    chk("hold_load_cnt", shift_cnt, 8'd0);

    // STEP 10 interrupted by asynchronous reset after 4 shifts
    issue(OP_STEP, 8'd10);
    repeat (4) tick();
    chk("mid_cnt", shift_cnt, 8'd4);
    chk("mid_busy", {7'd0, busy}, 8'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_q", lfsr_q, 8'h01);
    chk("arst_busy", {7'd0, busy}, 8'd0);
    chk("arst_cnt", shift_cnt, 8'd0);
    chk("arst_ready", {7'd0, cmd_ready}, 8'd1);
    #1 rst_n = 1'b1;
    tick();
    chk("post_rst_q", lfsr_q, 8'h01);
    chk("post_rst_busy", {7'd0, busy}, 8'd0);

    // RUN for 255 shifts with a discarded LOAD mid-run, then STOP
    issue(OP_LOAD, 8'h01);
    issue(OP_RUN, 8'h00);
    chk("run_busy0", {7'd0, busy}, 8'd1);
    hits = 0;
    for (int i = 1; i <= 255; i++) begin
      if (i == 100) begin
        cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_arg = 8'h33;
      end
      tick();
      cmd_valid = 1'b0;
      if (seed_hit) hits++;
      if (i == 1) chk("run_q1", lfsr_q, 8'h80);
      if (i == 100) chk("run_discard_cnt", shift_cnt, 8'd100);
    end
    chk("run_hits", hits[7:0], 8'd1);
    chk("run_hit_now", {7'd0, seed_hit}, 8'd1);
    chk("run_q255", lfsr_q, 8'h01);
    chk("run_cnt255", shift_cnt, 8'd255);
    issue(OP_STOP, 8'h00);
    chk("stop_q", lfsr_q, 8'h80);
    chk("stop_busy", {7'd0, busy}, 8'd0);
    chk("stop_cnt_wrap", shift_cnt, 8'd0);
    chk("stop_done", {7'd0, done}, 8'd0);
    repeat (3) tick();
    chk("stop_frozen", lfsr_q, 8'h80);

    // STOP in IDLE is ignored
    issue(OP_STOP, 8'h00);
    chk("idle_stop_busy", {7'd0, busy}, 8'd0);
    chk("idle_stop_q", lfsr_q, 8'h80);

    // Lockup behaviour with a zero seed
    issue(OP_LOAD, 8'h00);
    chk("zero_q", lfsr_q, 8'h00);
    chk("zero_lockup", {7'd0, lockup}, 8'd1);
    issue(OP_STEP, 8'd3);
    chk("zero_step_done", {7'd0, done}, 8'd1);
    chk("zero_step_busy", {7'd0, busy}, 8'd0);
    chk("zero_step_cnt", shift_cnt, 8'd0);
    issue(OP_RUN, 8'h00);
    tick();
    chk("zero_run_idle", {7'd0, busy}, 8'd0);
    chk("zero_run_q", lfsr_q, 8'h00);
    chk("zero_run_done", {7'd0, done}, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lfsr_ctrl.md
LFSR_CTRL -- requirements
Module: lfsr_ctrl

Interface
REQ-001 SHALL have parameter RST_SEED, default 8'h01, the LFSR value loaded on reset.
REQ-002 SHALL have parameter TAPS, default 8'b0001_1101, the mask of bits XORed into the feedback (bits 4,3,2,0).
REQ-003 SHALL have port clk  input  1  the single clock; all flops are rising-edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port cmd_valid  input  1  command present.
REQ-006 SHALL have port cmd_ready  output  1  command accepted this edge when high with cmd_valid.
REQ-007 SHALL have port cmd_op  input  2  opcode: 00 LOAD, 01 STEP, 10 RUN, 11 STOP.
REQ-008 SHALL have port cmd_arg  input  8  seed for LOAD, step count N for STEP, ignored otherwise.
REQ-009 SHALL have port lfsr_q  output  8  current LFSR value.
REQ-010 SHALL have port busy  output  1  high while STEP or RUN is executing.
REQ-011 SHALL have port done  output  1  one-cycle pulse on LOAD or STEP completion.
REQ-012 SHALL have port lockup  output  1  high whenever lfsr_q == 0.
REQ-013 SHALL have port shift_cnt  output  8  shifts since the last LOAD, mod 256.
REQ-014 SHALL have port seed_hit  output  1  one-cycle pulse when a shift returns lfsr_q to the last loaded seed.

Function
REQ-015 SHALL shift right on each shift edge: bit7 <= ^(lfsr_q & TAPS), bit i <= bit i+1 for i=6..0.
REQ-016 SHALL implement FSM states IDLE, STEP, RUN; cmd_ready = 1 in IDLE and RUN, 0 in STEP.
REQ-017 SHALL, in IDLE, accept LOAD at edge E0: lfsr_q=cmd_arg, shift_cnt=0, stored seed=cmd_arg; done=1 for the following cycle; the FSM stays in IDLE.
REQ-018 SHALL, in IDLE, accept STEP with N>0 at edge E0: enter STEP, shift at edges E1..EN, return to IDLE at EN, and pulse done for the cycle after EN.
REQ-019 SHALL treat STEP with N=0 as a no-op: no shift, stay in IDLE, done pulses for the cycle after E0.
REQ-020 SHALL, in IDLE, accept RUN at E0: enter RUN and shift on every edge from E1 until STOP is accepted; done never pulses for RUN.
REQ-021 SHALL, in RUN, accept STOP at edge Es: the shift still occurs at Es, the FSM enters IDLE, and no further shifts occur.
REQ-022 SHALL, in RUN, accept and discard LOAD, STEP and RUN with no state change; STOP in IDLE is accepted and ignored.
REQ-023 SHALL assert busy exactly while the FSM is in STEP or RUN.
REQ-024 SHALL suppress shifting while lfsr_q == 0: STEP completes as N=0 and RUN returns to IDLE on the next edge.
REQ-025 SHALL increment shift_cnt by one per shift, wrapping 255->0.
REQ-026 SHALL pulse seed_hit for the cycle after a shift whose result equals the stored seed; with default TAPS and a nonzero seed this occurs every 255 shifts.

Reset
REQ-027 SHALL, on rst_n low at any time (including mid-STEP or mid-RUN), force: FSM=IDLE, lfsr_q=RST_SEED, stored seed=RST_SEED, shift_cnt=0, busy=0, done=0, seed_hit=0, step counter=0.
REQ-028 SHALL drive cmd_ready=1 and lockup=(RST_SEED==0) immediately after reset release.

Structure
REQ-029 SHALL place opcode constants (OP_LOAD, OP_STEP, OP_RUN, OP_STOP) and the FSM state encoding in shared package lfsr_pkg.
REQ-030 SHALL contain one sub-module lfsr8_core (shift register + feedback, inputs: load, load_val, shift_en), with the FSM and counters in lfsr_ctrl.

Verification
REQ-031 SHALL cover: reset, then LOAD 0x01 -> lfsr_q=0x01, done pulse, shift_cnt=0.
REQ-032 SHALL cover: LOAD 0x01, then STEP 5 -> lfsr_q sequence 0x80,0x40,0x20,0x10,0x88; busy for 5 cycles; single done; shift_cnt=5.
REQ-033 SHALL cover: LOAD 0x01, RUN for 255 shifts -> seed_hit pulses exactly once when lfsr_q returns to 0x01; STOP -> busy=0 and lfsr_q frozen.
REQ-034 SHALL cover: LOAD 0x00 -> lockup=1; STEP 3 -> no shift, done the next cycle; RUN -> IDLE within 2 edges.
REQ-035 SHALL cover: STEP 10 with rst_n pulsed low after 4 shifts -> lfsr_q=RST_SEED, busy=0 asynchronously; cmd_valid held during STEP -> cmd_ready=0, command accepted only after done.
